// File: rtl/rx_dec8b10b_nsym.sv
// Multi-symbol 8b/10b receive decoder with running-disparity tracking,
// comma-based word sync FSM and a saturating errored-symbol counter.
module rx_dec8b10b_nsym #(
   parameter int NSYM      = 2,
   parameter int SYNC_GOOD = 4,
   parameter int LOS_ERR   = 3,
   parameter int CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [10*NSYM-1:0]    in_data,
   input  logic                  cnt_clr,
   output logic                  out_valid,
   output logic [9*NSYM-1:0]     out_data,
   output logic [NSYM-1:0]       out_code_err,
   output logic [NSYM-1:0]       out_disp_err,
   output logic                  rd_out,
   output logic [1:0]            sync_state,
   output logic [CNT_W-1:0]      err_cnt
);

   typedef struct packed {
      logic [8:0] dat;
      logic       code_err;
      logic       disp_err;
      logic       rd;
   } sym_res_t;

   typedef enum logic [1:0] {ST_LOS = 2'd0, ST_ACQ = 2'd1, ST_SYNC = 2'd2} state_t;

   function automatic sym_res_t dec_sym(input logic [9:0] sym, input logic rd_in);
      logic [5:0] c6;
      logic [3:0] c4, c4d;
      logic [4:0] x;
      logic [2:0] y, n6, n4;
      logic       e6, e4, k28, p7, a7, xa, xb, xk, rd_mid, d6, d4;
      sym_res_t   r;
      c6 = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
      c4 = {sym[6], sym[7], sym[8], sym[9]};
      n6 = 3'(sym[0]) + 3'(sym[1]) + 3'(sym[2]) + 3'(sym[3]) + 3'(sym[4]) + 3'(sym[5]);
      n4 = 3'(sym[6]) + 3'(sym[7]) + 3'(sym[8]) + 3'(sym[9]);
      x = '0; e6 = 1'b0; k28 = 1'b0;
      case (c6)
         6'b100111, 6'b011000: x = 5'd0;
         6'b011101, 6'b100010: x = 5'd1;
         6'b101101, 6'b010010: x = 5'd2;
         6'b110001:            x = 5'd3;
         6'b110101, 6'b001010: x = 5'd4;
         6'b101001:            x = 5'd5;
         6'b011001:            x = 5'd6;
         6'b111000, 6'b000111: x = 5'd7;
         6'b111001, 6'b000110: x = 5'd8;
         6'b100101:            x = 5'd9;
         6'b010101:            x = 5'd10;
         6'b110100:            x = 5'd11;
         6'b001101:            x = 5'd12;
         6'b101100:            x = 5'd13;
         6'b011100:            x = 5'd14;
         6'b010111, 6'b101000: x = 5'd15;
         6'b011011, 6'b100100: x = 5'd16;
         6'b100011:            x = 5'd17;
         6'b010011:            x = 5'd18;
         6'b110010:            x = 5'd19;
         6'b001011:            x = 5'd20;
         6'b101010:            x = 5'd21;
         6'b011010:            x = 5'd22;
         6'b111010, 6'b000101: x = 5'd23;
         6'b110011, 6'b001100: x = 5'd24;
         6'b100110:            x = 5'd25;
         6'b010110:            x = 5'd26;
         6'b110110, 6'b001001: x = 5'd27;
         6'b001110:            x = 5'd28;
         6'b101110, 6'b010001: x = 5'd29;
         6'b011110, 6'b100001: x = 5'd30;
         6'b101011, 6'b010100: x = 5'd31;
         6'b001111, 6'b110000: begin x = 5'd28; k28 = 1'b1; end
         default:              e6 = 1'b1;
      endcase
      // K28 in its RD+ form carries a complemented 4b group (K28.1/.2/.5/.6 swap)
      c4d = (c6 == 6'b110000) ? ~c4 : c4;
      y = '0; e4 = 1'b0; p7 = 1'b0; a7 = 1'b0;
      case (c4d)
         4'b1011, 4'b0100: y = 3'd0;
         4'b1001:          y = 3'd1;
         4'b0101:          y = 3'd2;
         4'b1100, 4'b0011: y = 3'd3;
         4'b1101, 4'b0010: y = 3'd4;
         4'b1010:          y = 3'd5;
         4'b0110:          y = 3'd6;
         4'b1110, 4'b0001: begin y = 3'd7; p7 = 1'b1; end
         4'b0111, 4'b1000: begin y = 3'd7; a7 = 1'b1; end
         default:          e4 = 1'b1;
      endcase
      xa = !e6 && (x == 5'd17 || x == 5'd18 || x == 5'd20);
      xb = !e6 && (x == 5'd11 || x == 5'd13 || x == 5'd14);
      xk = !e6 && (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30);
      // A7 is only legal for the run-length cases or as K.x.7; P7 is illegal where A7 is mandatory
      r.code_err = e6 | e4
                 | (a7 & ~(k28 | xk | (xa && c4 == 4'b0111) | (xb && c4 == 4'b1000)))
                 | (p7 & (k28 | (xa && c4 == 4'b1110) | (xb && c4 == 4'b0001)));
      d6     = rd_in ? (n6 == 3'd4 || c6 == 6'b111000) : (n6 == 3'd2 || c6 == 6'b000111);
      rd_mid = (n6 > 3'd3) ? 1'b1 : (n6 < 3'd3) ? 1'b0 : rd_in;
      d4     = rd_mid ? (n4 == 3'd3 || c4 == 4'b1100) : (n4 == 3'd1 || c4 == 4'b0011);
      r.disp_err = d6 | d4;
      r.rd       = (n4 > 3'd2) ? 1'b1 : (n4 < 3'd2) ? 1'b0 : rd_mid;
      r.dat      = {k28 | (a7 & xk), y, x};
      return r;
   endfunction

   logic                     r_rd, r_ov;
   logic [9*NSYM-1:0]        r_data;
   logic [NSYM-1:0]          r_cerr, r_derr;
   logic [CNT_W-1:0]         r_cnt;
   logic [3:0]               r_good, r_bad;
   state_t                   r_state;

   logic [NSYM:0]            w_rd_chain;
   logic [NSYM-1:0][8:0]     w_dat;
   logic [NSYM-1:0]          w_cerr, w_derr;
   logic                     w_word_err, w_comma;
   logic [3:0]               w_nerr, w_good_nxt, w_bad_nxt;
   logic [CNT_W:0]           w_sum;
   logic [CNT_W-1:0]         w_cnt_sat;
   state_t                   w_state_nxt;

   // Disparity ripples symbol to symbol within the cycle
   assign w_rd_chain[0] = r_rd;
   for (genvar g = 0; g < NSYM; g++) begin : g_sym
      sym_res_t w_res;
      assign w_res             = dec_sym(in_data[10*g +: 10], w_rd_chain[g]);
      assign w_dat[g]          = w_res.dat;
      assign w_cerr[g]         = w_res.code_err;
      assign w_derr[g]         = w_res.disp_err;
      assign w_rd_chain[g+1]   = w_res.rd;
   end

   always_comb begin
      w_nerr  = '0;
      w_comma = 1'b0;
      for (int s = 0; s < NSYM; s++) begin
         w_nerr  = w_nerr + 4'(w_cerr[s] | w_derr[s]);
         w_comma = w_comma | (w_dat[s] == 9'h1BC);
      end
      w_word_err = |(w_cerr | w_derr);
      w_comma    = w_comma & ~w_word_err;
   end

   assign w_sum     = {1'b0, r_cnt} + (CNT_W+1)'(w_nerr);
   assign w_cnt_sat = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_bad_nxt   = r_bad;
      if (in_valid) begin
         case (r_state)
            ST_LOS: if (w_comma) begin
               w_state_nxt = ST_ACQ;
               w_good_nxt  = 4'd1;
            end
            ST_ACQ: if (w_word_err) begin
               w_state_nxt = ST_LOS;
               w_good_nxt  = '0;
            end else begin
               w_good_nxt = r_good + 4'd1;
               if (r_good + 4'd1 == 4'(SYNC_GOOD)) begin
                  w_state_nxt = ST_SYNC;
                  w_bad_nxt   = '0;
               end
            end
            ST_SYNC: if (w_word_err) begin
               w_bad_nxt = r_bad + 4'd1;
               if (r_bad + 4'd1 == 4'(LOS_ERR)) begin
                  w_state_nxt = ST_LOS;
                  w_good_nxt  = '0;
                  w_bad_nxt   = '0;
               end
            end else begin
               w_bad_nxt = '0;
            end
            default: w_state_nxt = ST_LOS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd    <= 1'b0;
         r_ov    <= 1'b0;
         r_data  <= '0;
         r_cerr  <= '0;
         r_derr  <= '0;
         r_cnt   <= '0;
         r_good  <= '0;
         r_bad   <= '0;
         r_state <= ST_LOS;
      end else begin
         r_ov    <= in_valid;
         r_data  <= in_valid ? w_dat  : '0;
         r_cerr  <= in_valid ? w_cerr : '0;
         r_derr  <= in_valid ? w_derr : '0;
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
         r_bad   <= w_bad_nxt;
         if (in_valid) r_rd <= w_rd_chain[NSYM];
         if (cnt_clr)       r_cnt <= in_valid ? CNT_W'(w_nerr) : '0;
         else if (in_valid) r_cnt <= w_cnt_sat;
      end
   end

   assign out_valid    = r_ov;
   assign out_data     = r_data;
   assign out_code_err = r_cerr;
   assign out_disp_err = r_derr;
   assign rd_out       = r_rd;
   assign sync_state   = r_state;
   assign err_cnt      = r_cnt;

endmodule

// File: tb/tb_rx_dec8b10b_nsym.sv
// Directed bench for rx_dec8b10b_nsym (NSYM=2, CNT_W=4): decode, disparity
// chaining, sync acquire/loss, counter saturation/clear and reset priority.
module tb_rx_dec8b10b_nsym;
   localparam int NSYM  = 2;
   localparam int CNT_W = 4;

   logic              clk = 1'b0;
   logic              rst, in_valid, cnt_clr;
   logic [10*NSYM-1:0] in_data;
   logic              out_valid, rd_out;
   logic [9*NSYM-1:0] out_data;
   logic [NSYM-1:0]   out_code_err, out_disp_err;
   logic [1:0]        sync_state;
   logic [CNT_W-1:0]  err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // {sym1, sym0}: K28.5 RD- / RD+ and D21.5
   localparam logic [19:0] W_CM = {10'h155, 10'h17C};
   localparam logic [19:0] W_CP = {10'h155, 10'h283};
   localparam logic [19:0] W_Z  = {10'h000, 10'h000};
   localparam logic [17:0] D_OK = {9'h0B5, 9'h1BC};
   localparam logic [17:0] D_KK = {9'h1BC, 9'h1BC};

   rx_dec8b10b_nsym #(.NSYM(NSYM), .SYNC_GOOD(4), .LOS_ERR(3), .CNT_W(CNT_W)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .cnt_clr(cnt_clr),
      .out_valid(out_valid), .out_data(out_data), .out_code_err(out_code_err),
      .out_disp_err(out_disp_err), .rd_out(rd_out), .sync_state(sync_state), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; cnt_clr = 1'b1; in_data = W_CM;
      for (int i = 0; i < 2; i++) begin
         cyc();
         n_cmp++;
         if ({out_valid, out_data, out_code_err, out_disp_err} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_out cyc%0d got %h want 0", i, {out_valid, out_data, out_code_err, out_disp_err});
         end
         n_cmp++;
         if ({rd_out, sync_state, err_cnt} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_state cyc%0d got rd=%0d sync=%0d cnt=%0d want 0", i, rd_out, sync_state, err_cnt);
         end
      end
      rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
      cyc();
   endtask

   task automatic test_decode();
      in_valid = 1'b1; in_data = W_CM;
      cyc();
      n_cmp++;
      if ({out_valid, out_data, out_code_err, out_disp_err} !== {1'b1, D_OK, 4'b0}) begin
         n_bad++;
         $display("FAIL decode_out got v=%0d d=%h ce=%b de=%b want v=1 d=%h ce=00 de=00",
                  out_valid, out_data, out_code_err, out_disp_err, D_OK);
      end
      n_cmp++;
      if ({rd_out, sync_state, err_cnt} !== {1'b1, 2'd1, 4'd0}) begin
         n_bad++;
         $display("FAIL decode_state got rd=%0d sync=%0d cnt=%0d want rd=1 sync=1 cnt=0", rd_out, sync_state, err_cnt);
      end
   endtask

   // Each comma flips RD, so the clean words alternate K28.5+ / K28.5- forms
   task automatic test_sync_acquire();
      logic [19:0] din [3];
      logic        erd [3];
      logic [1:0]  esy [3];
      din = '{W_CP, W_CM, W_CP};
      erd = '{1'b0, 1'b1, 1'b0};
      esy = '{2'd1, 2'd1, 2'd2};
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = din[i];
         cyc();
         n_cmp++;
         if ({out_valid, out_data, out_code_err, out_disp_err} !== {1'b1, D_OK, 4'b0}) begin
            n_bad++;
            $display("FAIL acq_out[%0d] got d=%h ce=%b de=%b want d=%h clean", i, out_data, out_code_err, out_disp_err, D_OK);
         end
         n_cmp++;
         if ({rd_out, sync_state, err_cnt} !== {erd[i], esy[i], 4'd0}) begin
            n_bad++;
            $display("FAIL acq_state[%0d] got rd=%0d sync=%0d cnt=%0d want rd=%0d sync=%0d cnt=0",
                     i, rd_out, sync_state, err_cnt, erd[i], esy[i]);
         end
      end
   endtask

   task automatic test_disp_err();
      in_valid = 1'b1; in_data = W_CM;
      cyc();
      n_cmp++;
      if ({rd_out, sync_state, err_cnt, out_disp_err} !== {1'b1, 2'd2, 4'd0, 2'b00}) begin
         n_bad++;
         $display("FAIL disp_setup got rd=%0d sync=%0d cnt=%0d de=%b want rd=1 sync=2 cnt=0 de=00",
                  rd_out, sync_state, err_cnt, out_disp_err);
      end
      in_data = W_CM;
      cyc();
      n_cmp++;
      if ({out_code_err, out_disp_err} !== 4'b00_01) begin
         n_bad++;
         $display("FAIL disp_flags got ce=%b de=%b want ce=00 de=01", out_code_err, out_disp_err);
      end
      n_cmp++;
      if ({rd_out, sync_state, err_cnt} !== {1'b1, 2'd2, 4'd1}) begin
         n_bad++;
         $display("FAIL disp_state got rd=%0d sync=%0d cnt=%0d want rd=1 sync=2 cnt=1", rd_out, sync_state, err_cnt);
      end
   endtask

   // Clean word, 2 errors, clean word (bad count restarts), then 3 errors drop sync
   task automatic test_loss_of_sync();
      logic [19:0] din [7];
      logic [1:0]  ece [7];
      logic        erd [7];
      logic [1:0]  esy [7];
      logic [3:0]  ecn [7];
      din = '{W_CP, W_Z, W_Z, W_CM, W_Z, W_Z, W_Z};
      ece = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
      erd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      esy = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      ecn = '{4'd1, 4'd3, 4'd5, 4'd5, 4'd7, 4'd9, 4'd11};
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_data = din[i];
         cyc();
         n_cmp++;
         if ({out_valid, out_code_err, out_disp_err} !== {1'b1, ece[i], 2'b00}) begin
            n_bad++;
            $display("FAIL los_flags[%0d] got v=%0d ce=%b de=%b want v=1 ce=%b de=00",
                     i, out_valid, out_code_err, out_disp_err, ece[i]);
         end
         n_cmp++;
         if ({rd_out, sync_state, err_cnt} !== {erd[i], esy[i], ecn[i]}) begin
            n_bad++;
            $display("FAIL los_state[%0d] got rd=%0d sync=%0d cnt=%0d want rd=%0d sync=%0d cnt=%0d",
                     i, rd_out, sync_state, err_cnt, erd[i], esy[i], ecn[i]);
         end
      end
   endtask

   task automatic test_saturate_clear();
      logic [3:0] ecn [3];
      ecn = '{4'd13, 4'd15, 4'd15};
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = W_Z;
         cyc();
         n_cmp++;
         if ({sync_state, err_cnt} !== {2'd0, ecn[i]}) begin
            n_bad++;
            $display("FAIL sat_cnt[%0d] got sync=%0d cnt=%0d want sync=0 cnt=%0d", i, sync_state, err_cnt, ecn[i]);
         end
      end
      in_valid = 1'b0; in_data = W_Z;
      cyc();
      n_cmp++;
      if ({out_valid, out_data, out_code_err, out_disp_err} !== 23'd0) begin
         n_bad++;
         $display("FAIL idle_out got %h want 0", {out_valid, out_data, out_code_err, out_disp_err});
      end
      n_cmp++;
      if ({rd_out, sync_state, err_cnt} !== {1'b0, 2'd0, 4'd15}) begin
         n_bad++;
         $display("FAIL idle_hold got rd=%0d sync=%0d cnt=%0d want rd=0 sync=0 cnt=15", rd_out, sync_state, err_cnt);
      end
      in_valid = 1'b1; cnt_clr = 1'b1; in_data = {10'h155, 10'h000};
      cyc();
      n_cmp++;
      if ({out_code_err, out_disp_err, err_cnt} !== {2'b01, 2'b00, 4'd1}) begin
         n_bad++;
         $display("FAIL clr_valid got ce=%b de=%b cnt=%0d want ce=01 de=00 cnt=1", out_code_err, out_disp_err, err_cnt);
      end
      in_valid = 1'b0;
      cyc();
      n_cmp++;
      if ({out_valid, err_cnt} !== {1'b0, 4'd0}) begin
         n_bad++;
         $display("FAIL clr_idle got v=%0d cnt=%0d want v=0 cnt=0", out_valid, err_cnt);
      end
      cnt_clr = 1'b0;
   endtask

   // Symbol 1 must see symbol 0's disparity from the same cycle
   task automatic test_back_to_back();
      in_valid = 1'b1; in_data = {10'h283, 10'h17C};
      cyc();
      n_cmp++;
      if ({out_data, out_code_err, out_disp_err} !== {D_KK, 4'b0}) begin
         n_bad++;
         $display("FAIL chain_ok got d=%h ce=%b de=%b want d=%h clean", out_data, out_code_err, out_disp_err, D_KK);
      end
      n_cmp++;
      if ({rd_out, sync_state, err_cnt} !== {1'b0, 2'd1, 4'd0}) begin
         n_bad++;
         $display("FAIL chain_state got rd=%0d sync=%0d cnt=%0d want rd=0 sync=1 cnt=0", rd_out, sync_state, err_cnt);
      end
      in_data = {10'h17C, 10'h283};
      cyc();
      n_cmp++;
      if ({out_data, out_code_err, out_disp_err} !== {D_KK, 2'b00, 2'b01}) begin
         n_bad++;
         $display("FAIL chain_err got d=%h ce=%b de=%b want d=%h ce=00 de=01", out_data, out_code_err, out_disp_err, D_KK);
      end
      n_cmp++;
      if ({rd_out, sync_state, err_cnt} !== {1'b1, 2'd0, 4'd1}) begin
         n_bad++;
         $display("FAIL chain_err_state got rd=%0d sync=%0d cnt=%0d want rd=1 sync=0 cnt=1", rd_out, sync_state, err_cnt);
      end
      rst = 1'b1; cnt_clr = 1'b0; in_data = W_CM;
      cyc();
      n_cmp++;
      if ({out_valid, rd_out, sync_state, err_cnt} !== 8'd0) begin
         n_bad++;
         $display("FAIL rst_prio got v=%0d rd=%0d sync=%0d cnt=%0d want all 0", out_valid, rd_out, sync_state, err_cnt);
      end
      rst = 1'b0; in_valid = 1'b0;
      cyc();
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; in_data = '0;
      test_reset();
      test_decode();
      test_sync_acquire();
      test_disp_err();
      test_loss_of_sync();
      test_saturate_clear();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
